// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory pipeline stage: opcodes, FSM states and
// default cache geometry with derived address-field widths.
package mem_stage_pkg;

  localparam logic [6:0] OP_ADD = 7'h00;
  localparam logic [6:0] OP_SUB = 7'h01;
  localparam logic [6:0] OP_MUL = 7'h02;
  localparam logic [6:0] OP_LDW = 7'h10;
  localparam logic [6:0] OP_STW = 7'h11;
  localparam logic [6:0] OP_NOP = 7'h3F;

  localparam int unsigned DEF_LINES     = 4;
  localparam int unsigned DEF_WORDS     = 4;
  localparam int unsigned BYTE_OFF_BITS = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_WRITE
  } state_t;

  // Tag is whatever remains of the 32-bit address above index, word and byte fields.
  function automatic int unsigned tag_bits(input int unsigned lines, input int unsigned words);
    return 32 - BYTE_OFF_BITS - $clog2(lines) - $clog2(words);
  endfunction

endpackage

// File: rtl/mem_stage_dcache_array.sv
// Direct-mapped cache storage: per-line valid, tag and data, one combinational
// read port and one full-line write port. Only valid bits are reset.
module dcache_array
  import mem_stage_pkg::*;
#(
  parameter int unsigned LINES = DEF_LINES,
  parameter int unsigned WORDS = DEF_WORDS
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [$clog2(LINES)-1:0]               rd_index,
  output logic                                   rd_valid,
  output logic [tag_bits(LINES, WORDS)-1:0]      rd_tag,
  output logic [32*WORDS-1:0]                    rd_line,
  input  logic                                   wr_en,
  input  logic [$clog2(LINES)-1:0]               wr_index,
  input  logic [tag_bits(LINES, WORDS)-1:0]      wr_tag,
  input  logic [32*WORDS-1:0]                    wr_line
);

  localparam int unsigned TB = tag_bits(LINES, WORDS);

  logic [LINES-1:0]    valid;
  logic [TB-1:0]       tags [LINES];
  logic [32*WORDS-1:0] data [LINES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_index] <= wr_tag;
      data[wr_index] <= wr_line;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_line  = data[rd_index];

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage with a direct-mapped, write-through, no-write-allocate
// data cache; misses and stores go to main memory through a req/ack handshake.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned LINES = DEF_LINES,
  parameter int unsigned WORDS = DEF_WORDS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [6:0]            opcode,
  input  logic [31:0]           addr_in,
  input  logic [31:0]           store_data,
  input  logic [4:0]            dstin,
  output logic [31:0]           result,
  output logic [4:0]            dstout,
  output logic [31:0]           bp_data_mem,
  output logic [4:0]            bp_reg_mem,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [32*WORDS-1:0]   mem_rdata
);

  localparam int unsigned WB = $clog2(WORDS);
  localparam int unsigned IB = $clog2(LINES);
  localparam int unsigned TB = tag_bits(LINES, WORDS);
  localparam int unsigned LW = 32 * WORDS;

  state_t        state;
  logic [IB-1:0] pend_index;
  logic [TB-1:0] pend_tag;
  logic [WB-1:0] pend_word;

  logic [WB-1:0] word_sel;
  logic [IB-1:0] index;
  logic [TB-1:0] tag;

  logic          rd_valid;
  logic [TB-1:0] rd_tag;
  logic [LW-1:0] rd_line;
  logic          wr_en;
  logic [IB-1:0] wr_index;
  logic [TB-1:0] wr_tag;
  logic [LW-1:0] wr_line;

  logic          is_ldw, is_stw, hit, launch;
  logic [31:0]   cached_word, fill_word;

  assign word_sel = addr_in[BYTE_OFF_BITS +: WB];
  assign index    = addr_in[BYTE_OFF_BITS + WB +: IB];
  assign tag      = addr_in[31 -: TB];

  assign is_ldw      = (opcode == OP_LDW);
  assign is_stw      = (opcode == OP_STW);
  assign hit         = rd_valid && (rd_tag == tag);
  assign launch      = (state == S_IDLE) && enable;
  assign cached_word = rd_line[{word_sel, 5'b0} +: 32];
  assign fill_word   = mem_rdata[{pend_word, 5'b0} +: 32];

  assign stall = (launch && ((is_ldw && !hit) || is_stw)) ||
                 ((state != S_IDLE) && !mem_ack);

  assign bp_data_mem = result;
  assign bp_reg_mem  = dstout;

  dcache_array #(
    .LINES(LINES),
    .WORDS(WORDS)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_index (index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .wr_en    (wr_en),
    .wr_index (wr_index),
    .wr_tag   (wr_tag),
    .wr_line  (wr_line)
  );

  // A store hit rewrites its whole line with just the addressed word replaced.
  always_comb begin
    wr_en    = 1'b0;
    wr_index = index;
    wr_tag   = tag;
    wr_line  = rd_line;
    if ((state == S_FILL) && mem_ack) begin
      wr_en    = 1'b1;
      wr_index = pend_index;
      wr_tag   = pend_tag;
      wr_line  = mem_rdata;
    end else if (launch && is_stw && hit) begin
      wr_en = 1'b1;
      wr_line[{word_sel, 5'b0} +: 32] = store_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pend_index <= '0;
      pend_tag   <= '0;
      pend_word  <= '0;
      result     <= '0;
      dstout     <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable) begin
            if (is_ldw && !hit) begin
              state      <= S_FILL;
              pend_index <= index;
              pend_tag   <= tag;
              pend_word  <= word_sel;
              mem_req    <= 1'b1;
              mem_we     <= 1'b0;
              mem_addr   <= {addr_in[31:BYTE_OFF_BITS+WB], {(BYTE_OFF_BITS+WB){1'b0}}};
              dstout     <= '0;
            end else if (is_stw) begin
              state     <= S_WRITE;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= {addr_in[31:BYTE_OFF_BITS], {BYTE_OFF_BITS{1'b0}}};
              mem_wdata <= store_data;
              dstout    <= '0;
            end else begin
              case (opcode)
                OP_ADD, OP_SUB, OP_MUL: begin
                  result <= addr_in;
                  dstout <= dstin;
                end
                OP_LDW: begin
                  result <= cached_word;
                  dstout <= dstin;
                end
                OP_NOP: begin
                  result <= addr_in;
                  dstout <= '0;
                end
                default: begin
                  result <= '1;
                  dstout <= dstin;
                end
              endcase
            end
          end
        end
        S_FILL, S_WRITE: begin
          if (mem_ack) begin
            state   <= S_IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (enable) begin
              if (state == S_FILL) begin
                result <= fill_word;
                dstout <= dstin;
              end else begin
                dstout <= '0;
              end
            end
          end else if (enable) begin
            dstout <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: ALU pass-through, load miss/hit,
// write-through store, conflict eviction, frozen ack and reset mid-fill.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic         clk = 1'b0;
  logic         rst, enable, mem_ack;
  logic [6:0]   opcode;
  logic [31:0]  addr_in, store_data;
  logic [4:0]   dstin;
  logic [31:0]  result, bp_data_mem, mem_addr, mem_wdata;
  logic [4:0]   dstout, bp_reg_mem;
  logic         stall, mem_req, mem_we;
  logic [127:0] mem_rdata;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned stall_cycles;

  always #5 clk = ~clk;

  mem_stage #(
    .LINES(4),
    .WORDS(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .opcode      (opcode),
    .addr_in     (addr_in),
    .store_data  (store_data),
    .dstin       (dstin),
    .result      (result),
    .dstout      (dstout),
    .bp_data_mem (bp_data_mem),
    .bp_reg_mem  (bp_reg_mem),
    .stall       (stall),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [31:0] a, input logic [4:0] d);
    opcode  = op;
    addr_in = a;
    dstin   = d;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    store_data = '0;
    drive(OP_NOP, 32'h0, 5'd0);
    step(); step();
    chk("rst_result", result, 32'h0);
    chk("rst_dstout", {27'd0, dstout}, 32'h0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'h0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_stall", {31'd0, stall}, 32'h0);
    rst = 1'b0;
    enable = 1'b1;

    // ALU pass-through, unknown opcode, nop, sub
    drive(OP_ADD, 32'd7, 5'd3); #1;
    chk("add_stall", {31'd0, stall}, 32'h0);
    step();
    chk("add_result", result, 32'd7);
    chk("add_bp_reg", {27'd0, bp_reg_mem}, 32'd3);
    chk("add_bp_data", bp_data_mem, 32'd7);
    drive(7'h2A, 32'h1234, 5'd4); step();
    chk("unk_result", result, 32'hFFFFFFFF);
    chk("unk_dstout", {27'd0, dstout}, 32'd4);
    drive(OP_NOP, 32'd9, 5'd5); step();
    chk("nop_result", result, 32'd9);
    chk("nop_dstout", {27'd0, dstout}, 32'd0);
    drive(OP_SUB, 32'h55, 5'd6); step();
    chk("sub_result", result, 32'h55);
    chk("sub_dstout", {27'd0, dstout}, 32'd6);

    // Cold load miss at 0x44, ack after three fill cycles
    drive(OP_LDW, 32'h44, 5'd7); #1;
    chk("miss_stall0", {31'd0, stall}, 32'h1);
    stall_cycles = {31'd0, stall};
    step();
    chk("miss_req", {31'd0, mem_req}, 32'h1);
    chk("miss_we", {31'd0, mem_we}, 32'h0);
    chk("miss_addr", mem_addr, 32'h40);
    chk("miss_bubble", {27'd0, dstout}, 32'd0);
    chk("miss_result_held", result, 32'h55);
    stall_cycles += {31'd0, stall};
    step();
    stall_cycles += {31'd0, stall};
    step();
    stall_cycles += {31'd0, stall};
    step();
    mem_ack = 1'b1;
    mem_rdata = {32'h33330000, 32'h22220000, 32'hDEADBEEF, 32'h11110000};
    #1;
    chk("miss_ack_stall", {31'd0, stall}, 32'h0);
    step();
    mem_ack = 1'b0;
    chk("miss_stall_cycles", stall_cycles, 32'd4);
    chk("miss_result", result, 32'hDEADBEEF);
    chk("miss_dstout", {27'd0, dstout}, 32'd7);
    chk("miss_req_drop", {31'd0, mem_req}, 32'h0);

    // Hits on the filled line
    drive(OP_LDW, 32'h44, 5'd8); #1;
    chk("hit_stall", {31'd0, stall}, 32'h0);
    step();
    chk("hit_result", result, 32'hDEADBEEF);
    chk("hit_dstout", {27'd0, dstout}, 32'd8);
    drive(OP_LDW, 32'h4C, 5'd9); step();
    chk("hit_w3_result", result, 32'h33330000);

    // Write-through store hit, then load sees new word
    drive(OP_STW, 32'h44, 5'd0); store_data = 32'h12345678; #1;
    chk("stw_stall", {31'd0, stall}, 32'h1);
    step();
    chk("stw_we", {31'd0, mem_we}, 32'h1);
    chk("stw_addr", mem_addr, 32'h44);
    chk("stw_wdata", mem_wdata, 32'h12345678);
    chk("stw_bubble", {27'd0, dstout}, 32'd0);
    step();
    chk("stw_we_hold", {31'd0, mem_we}, 32'h1);
    chk("stw_addr_hold", mem_addr, 32'h44);
    mem_ack = 1'b1; #1;
    chk("stw_ack_stall", {31'd0, stall}, 32'h0);
    step();
    mem_ack = 1'b0;
    chk("stw_req_drop", {31'd0, mem_req}, 32'h0);
    chk("stw_dstout", {27'd0, dstout}, 32'd0);
    drive(OP_LDW, 32'h44, 5'd10); #1;
    chk("ld_after_st_stall", {31'd0, stall}, 32'h0);
    step();
    chk("ld_after_st_result", result, 32'h12345678);
    chk("ld_after_st_dst", {27'd0, dstout}, 32'd10);

    // Stray ack while idle is ignored
    drive(OP_NOP, 32'h0, 5'd0); mem_ack = 1'b1; #1;
    chk("stray_stall", {31'd0, stall}, 32'h0);
    step();
    mem_ack = 1'b0;
    chk("stray_req", {31'd0, mem_req}, 32'h0);

    // Conflict miss: 0x80 shares index 0 with 0x40
    drive(OP_LDW, 32'h80, 5'd11); #1;
    chk("conf_stall", {31'd0, stall}, 32'h1);
    step();
    chk("conf_addr", mem_addr, 32'h80);
    chk("conf_bubble0", {27'd0, dstout}, 32'd0);
    step();
    chk("conf_bubble1", {27'd0, dstout}, 32'd0);
    mem_ack = 1'b1;
    mem_rdata = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
    step();
    mem_ack = 1'b0;
    chk("conf_result", result, 32'hA0A0A0A0);
    chk("conf_dstout", {27'd0, dstout}, 32'd11);

    // 0x44 now evicted; ack arrives with enable low, then completes as hit
    drive(OP_LDW, 32'h44, 5'd12); #1;
    chk("evict_stall", {31'd0, stall}, 32'h1);
    step();
    chk("evict_addr", mem_addr, 32'h40);
    enable = 1'b0; mem_ack = 1'b1;
    mem_rdata = {32'h0, 32'h0, 32'h5555AAAA, 32'h0};
    #1;
    chk("frz_ack_stall", {31'd0, stall}, 32'h0);
    step();
    mem_ack = 1'b0;
    chk("frz_req", {31'd0, mem_req}, 32'h0);
    chk("frz_result", result, 32'hA0A0A0A0);
    chk("frz_dstout", {27'd0, dstout}, 32'd0);
    enable = 1'b1; #1;
    chk("frz_hit_stall", {31'd0, stall}, 32'h0);
    step();
    chk("frz_hit_result", result, 32'h5555AAAA);
    chk("frz_hit_dstout", {27'd0, dstout}, 32'd12);

    // Enable low freezes outputs in idle
    enable = 1'b0;
    drive(OP_ADD, 32'h99, 5'd2); step();
    chk("idle_frz_result", result, 32'h5555AAAA);
    chk("idle_frz_dstout", {27'd0, dstout}, 32'd12);
    enable = 1'b1;

    // Reset during fill abandons it; later ack ignored, cache invalid
    drive(OP_LDW, 32'hC4, 5'd13); #1;
    chk("rf_stall", {31'd0, stall}, 32'h1);
    step();
    chk("rf_req", {31'd0, mem_req}, 32'h1);
    rst = 1'b1; #1;
    chk("rf_rst_req", {31'd0, mem_req}, 32'h0);
    chk("rf_rst_result", result, 32'h0);
    chk("rf_rst_dstout", {27'd0, dstout}, 32'h0);
    chk("rf_rst_addr", mem_addr, 32'h0);
    step();
    rst = 1'b0;
    drive(OP_NOP, 32'h0, 5'd0);
    mem_ack = 1'b1; mem_rdata = {4{32'hBADBAD00}};
    step();
    mem_ack = 1'b0;
    chk("rf_ack_ignored", {31'd0, mem_req}, 32'h0);
    chk("rf_ack_result", result, 32'h0);
    drive(OP_LDW, 32'h44, 5'd14); #1;
    chk("rf_invalid_44", {31'd0, stall}, 32'h1);
    drive(OP_LDW, 32'hC4, 5'd14); #1;
    chk("rf_invalid_c4", {31'd0, stall}, 32'h1);
    enable = 1'b0;
    drive(OP_NOP, 32'h0, 5'd0);
    step();
    chk("end_req", {31'd0, mem_req}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter LINES, default 4, number of direct-mapped cache lines (power of two).
REQ-002 Parameter WORDS, default 4, 32-bit words per line; mem_rdata width is 32*WORDS.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 enable  in  1  pipeline advance; low freezes output registers and new-access launch.
REQ-006 opcode  in  7  op from execution stage: 0x00 add, 0x01 sub, 0x02 mul, 0x10 LDW, 0x11 STW, 0x3F nop.
REQ-007 addr_in  in  32  ALU result from execution; the address for LDW/STW.
REQ-008 store_data  in  32  STW data.
REQ-009 dstin  in  5  destination register; 0 = no writeback.
REQ-010 result  out  32  registered value to writeback.
REQ-011 dstout  out  5  registered destination to writeback.
REQ-012 bp_data_mem  out  32  bypass data to execution; equals result.
REQ-013 bp_reg_mem  out  5  bypass register to execution; equals dstout.
REQ-014 stall  out  1  combinational; high holds all upstream stages.
REQ-015 mem_req  out  1  main-memory request, held until mem_ack.
REQ-016 mem_we  out  1  1 = word write, 0 = line read.
REQ-017 mem_addr  out  32  line-aligned for reads, word address for writes.
REQ-018 mem_wdata  out  32  write data.
REQ-019 mem_ack  in  1  one-cycle completion; sampled only while mem_req=1.
REQ-020 mem_rdata  in  32*WORDS  fill line, valid in the mem_ack cycle; word 0 in bits 31:0.

Function
REQ-021 Address split: addr[1:0] ignored; addr[3:2] word; addr[5:4] index; addr[31:6] tag (default geometry).
REQ-022 FSM states IDLE, FILL, WRITE; only transitions: IDLE->FILL (LDW miss), IDLE->WRITE (STW), FILL->IDLE and WRITE->IDLE on mem_ack.
REQ-023 Launch from IDLE only when enable=1; mem_req, mem_we, mem_addr, mem_wdata registered on the launch edge.
REQ-024 stall = (IDLE & enable & (LDW miss | STW)) | (state!=IDLE & !mem_ack).
REQ-025 ALU ops/nop with enable=1, stall=0: result<=addr_in, dstout<=dstin (nop: dstout<=0); latency 1 cycle.
REQ-026 LDW hit: result<=cached word, dstout<=dstin, next edge, no stall.
REQ-027 LDW miss: on mem_ack edge, line written, valid set, tag stored; if enable=1, result<=mem_rdata selected word, dstout<=dstin.
REQ-028 STW: write-through, no write-allocate; hit also updates the cached word on the launch edge; on mem_ack, dstout<=0.
REQ-029 While stall=1, output registers load bubble: dstout<=0, result held.
REQ-030 mem_ack with enable=0: FSM returns IDLE, outputs frozen; the held LDW then completes as a hit.
REQ-031 Unknown opcode: result<=32'hFFFFFFFF, dstout<=dstin.
REQ-032 mem_ack while mem_req=0 ignored.

Reset
REQ-033 rst: state IDLE, all valid bits 0, result 0, dstout 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0.
REQ-034 Reset mid-FILL/WRITE abandons the access; no line written; a later stray mem_ack is ignored.

Structure
REQ-035 Shared package holds opcode constants, FSM state enum, LINES/WORDS defaults and derived field widths.
REQ-036 Sub-module dcache_array holds tag/valid/data storage with one read port and one write port.

Verification
REQ-037 LDW 0x40 cold, mem_ack after 3 cycles with word1=0xDEADBEEF at 0x44 access -> stall 4 cycles, result=0xDEADBEEF, dstout=dstin.
REQ-038 Repeat LDW 0x44 -> hit, no stall, result=0xDEADBEEF in 1 cycle.
REQ-039 STW 0x44 data 0x12345678 then LDW 0x44 -> mem_we=1, mem_addr=0x44 until ack; load hits 0x12345678.
REQ-040 LDW 0x40 then LDW 0x80 (same index, new tag) -> second misses and refills; dstout=0 during stalls.
REQ-041 rst asserted in FILL, then mem_ack pulse -> state IDLE, valid 0, outputs 0, ack ignored.
REQ-042 add with addr_in=7, dstin=3 -> result=7, bp_reg_mem=3 next cycle; opcode 0x2A -> result=0xFFFFFFFF.
